// File: rtl/clock_strobe_gen.sv
// Lock-qualified reset and per-channel strobe generator for a PLL clock domain.
// Build option: define CLOCK_STROBE_GEN_LOSS_COUNT_EN to implement the saturating loss counter.
module clock_strobe_gen #(
  parameter int                        NUM_CH    = 2,
  parameter int                        DIV_W     = 10,
  parameter logic [NUM_CH*DIV_W-1:0]   DIVS      = {10'd6, 10'd4},
  parameter int                        LOCK_WAIT = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              locked,
  input  logic              lost_clear,
  output logic              core_reset_n,
  output logic [NUM_CH-1:0] strobe,
  output logic              lost_lock,
  output logic [7:0]        loss_count,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_SETTLE    = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [7:0] SETTLE_LAST  = 8'(LOCK_WAIT - 1);

  logic       sync1_q, locked_sync_q;
  logic [1:0] state_q, state_d;
  logic [7:0] settle_q, settle_d;
  logic       core_rst_q, core_rst_d;
  logic       lost_q, lost_d;
  logic       loss_event;
  logic       stay_run;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q       <= 1'b0;
      locked_sync_q <= 1'b0;
      state_q       <= ST_WAIT_LOCK;
      settle_q      <= 8'd0;
      core_rst_q    <= 1'b0;
      lost_q        <= 1'b0;
    end else begin
      sync1_q       <= locked;
      locked_sync_q <= sync1_q;
      state_q       <= state_d;
      settle_q      <= settle_d;
      core_rst_q    <= core_rst_d;
      lost_q        <= lost_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = 8'd0;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (locked_sync_q) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!locked_sync_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = ST_RUN;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      ST_RUN: begin
        if (!locked_sync_q) state_d = ST_WAIT_LOCK;
      end
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  // Only a loss from RUN is a real lock loss; drops during SETTLE are ignored.
  assign loss_event = (state_q == ST_RUN) && !locked_sync_q;
  assign stay_run   = (state_q == ST_RUN) && (state_d == ST_RUN);

  always_comb begin
    core_rst_d = (state_d == ST_RUN);
    lost_d     = loss_event | (lost_q & ~lost_clear);
  end

  assign core_reset_n = core_rst_q;
  assign lost_lock    = lost_q;
  assign dbg_state    = state_q;

  // Dividers restart together on RUN entry so every channel is phase-aligned.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [DIV_W-1:0] DIV_LAST = DIVS[g*DIV_W +: DIV_W] - 1'b1;
    logic [DIV_W-1:0] div_q, div_d;

    always_comb begin
      div_d = '0;
      if (stay_run && (div_q != DIV_LAST)) div_d = div_q + DIV_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) div_q <= '0;
      else          div_q <= div_d;
    end

    assign strobe[g] = (state_q == ST_RUN) && (div_q == DIV_LAST);
  end

`ifdef CLOCK_STROBE_GEN_LOSS_COUNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (loss_event && (loss_cnt_q != 8'hFF)) loss_cnt_d = loss_cnt_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) loss_cnt_q <= 8'd0;
    else          loss_cnt_q <= loss_cnt_d;
  end

  assign loss_count = loss_cnt_q;
`else
  assign loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_clock_strobe_gen.sv
// Bench for clock_strobe_gen: directed lock scenarios plus random lock traffic,
// checked against a lock-streak reference model.
module tb_clock_strobe_gen;

  localparam int LOCK_WAIT = 16;

  logic       clock;
  logic       reset_n;
  logic       locked;
  logic       lost_clear;
  logic       core0, core1;
  logic [1:0] strobe0, strobe1;
  logic       lost0, lost1;
  logic [7:0] loss0, loss1;
  logic [1:0] dbg0, dbg1;

  int checks = 0;
  int errors = 0;

  // Channel divisors as the bench understands them.
  int div0[2] = '{4, 6};
  int div1[2] = '{1, 3};

  clock_strobe_gen dut (
    .clock(clock), .reset_n(reset_n), .locked(locked), .lost_clear(lost_clear),
    .core_reset_n(core0), .strobe(strobe0), .lost_lock(lost0),
    .loss_count(loss0), .dbg_state(dbg0)
  );

  clock_strobe_gen #(.DIVS({10'd3, 10'd1})) dut_div1 (
    .clock(clock), .reset_n(reset_n), .locked(locked), .lost_clear(lost_clear),
    .core_reset_n(core1), .strobe(strobe1), .lost_lock(lost1),
    .loss_count(loss1), .dbg_state(dbg1)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Output is in RUN when the lock samples seen two edges ago form an unbroken
  // run of at least LOCK_WAIT+1 highs since reset.
  int hist_q[$];
  int m_streak;
  bit m_run;
  int m_runc;
  bit m_lost;
  int m_cnt;

  initial begin
    m_streak = 0; m_run = 0; m_runc = 0; m_lost = 0; m_cnt = 0;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        hist_q.delete();
        m_streak = 0; m_run = 0; m_runc = 0; m_lost = 0; m_cnt = 0;
      end else begin
        bit new_run;
        hist_q.push_back(int'(locked));
        if (hist_q.size() > 2) begin
          int s;
          s = hist_q.pop_front();
          m_streak = (s != 0) ? ((m_streak < 100000) ? m_streak + 1 : m_streak) : 0;
        end
        new_run = (m_streak >= LOCK_WAIT + 1);
        if (m_run && !new_run) begin
          m_lost = 1;
          if (m_cnt < 255) m_cnt++;
        end else if (lost_clear) begin
          m_lost = 0;
        end
        m_runc = new_run ? m_runc + 1 : 0;
        m_run  = new_run;
      end
    end
  end

  function automatic int exp_loss(int n);
`ifdef CLOCK_STROBE_GEN_LOSS_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  function automatic logic [1:0] exp_strobe(int d0, int d1);
    logic [1:0] v;
    v[0] = m_run && ((m_runc % d0) == 0);
    v[1] = m_run && ((m_runc % d1) == 0);
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_core"},    32'(core0),   32'(m_run));
    chk({tag, "_strobe"},  32'(strobe0), 32'(exp_strobe(div0[0], div0[1])));
    chk({tag, "_lost"},    32'(lost0),   32'(m_lost));
    chk({tag, "_loss"},    32'(loss0),   32'(exp_loss(m_cnt)));
    chk({tag, "_core_d1"}, 32'(core1),   32'(m_run));
    chk({tag, "_strb_d1"}, 32'(strobe1), 32'(exp_strobe(div1[0], div1[1])));
  endtask

  task automatic run_cycles(int n, string tag);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
      check_all(tag);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_core"},    32'(core0),   0);
    chk({tag, "_strobe"},  32'(strobe0), 0);
    chk({tag, "_lost"},    32'(lost0),   0);
    chk({tag, "_loss"},    32'(loss0),   0);
    chk({tag, "_core_d1"}, 32'(core1),   0);
    chk({tag, "_strb_d1"}, 32'(strobe1), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset_n    = 1'b0;
    locked     = 1'b0;
    lost_clear = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;

    // Lock-up: locked rises 1 ns after edge 0.
    @(posedge clock);
    #1 locked = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("lockup_core_e%0d", e), 32'(core0), 32'(e >= 19));
      chk($sformatf("lockup_s0_e%0d", e), 32'(strobe0[0]), 32'(e == 22 || e == 26 || e == 30));
      chk($sformatf("lockup_s1_e%0d", e), 32'(strobe0[1]), 32'(e == 24 || e == 30));
      check_all("lockup");
    end

    // Lock loss in RUN: reset drops exactly three edges later.
    locked = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("loss_core_e%0d", e), 32'(core0), 32'(e < 3));
      check_all("loss");
    end
    chk("loss_strobe", 32'(strobe0), 0);
    chk("loss_lost", 32'(lost0), 1);
    chk("loss_count1", 32'(loss0), 32'(exp_loss(1)));
    lost_clear = 1'b1;
    run_cycles(1, "clear");
    lost_clear = 1'b0;
    chk("clear_lost", 32'(lost0), 0);
    chk("clear_count", 32'(loss0), 32'(exp_loss(1)));

    // Settle glitch: five cycles of lock, then gone.
    locked = 1'b1;
    run_cycles(5, "glitch_hi");
    locked = 1'b0;
    run_cycles(4, "glitch_lo");
    chk("glitch_core", 32'(core0), 0);
    chk("glitch_lost", 32'(lost0), 0);
    chk("glitch_count", 32'(loss0), 32'(exp_loss(1)));
    locked = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("relock_core_e%0d", e), 32'(core0), 32'(e >= 19));
      check_all("relock");
    end

    // Clear coinciding with a RUN loss: the set wins, a lone clear then wins.
    run_cycles(3, "pre_coll");
    locked = 1'b0;
    run_cycles(2, "coll_wait");
    lost_clear = 1'b1;
    run_cycles(1, "coll");
    chk("coll_lost_set", 32'(lost0), 1);
    chk("coll_count", 32'(loss0), 32'(exp_loss(2)));
    run_cycles(1, "coll_clear");
    chk("coll_lost_clr", 32'(lost0), 0);
    chk("coll_count_keep", 32'(loss0), 32'(exp_loss(2)));
    lost_clear = 1'b0;

    // Random glitches inside the settle window.
    for (int k = 0; k < 6; k++) begin
      locked = 1'b1;
      run_cycles($urandom_range(1, LOCK_WAIT), "rnd_glitch_hi");
      locked = 1'b0;
      run_cycles($urandom_range(2, 4), "rnd_glitch_lo");
    end

    // Random lock traffic with sporadic clears.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 24) == 0) locked = ~locked;
      lost_clear = ($urandom_range(0, 7) == 0);
      run_cycles(1, "random");
    end
    lost_clear = 1'b0;

    // Saturation: 260 complete lock/loss cycles.
    for (int k = 0; k < 260; k++) begin
      locked = 1'b1;
      run_cycles(20, "sat_hi");
      locked = 1'b0;
      run_cycles(3, "sat_lo");
    end
    chk("sat_count", 32'(loss0), 32'(exp_loss(255)));
    chk("sat_lost", 32'(lost0), 1);

    // Asynchronous reset mid-RUN, then a full re-settle with locked held high.
    locked = 1'b1;
    run_cycles(25, "pre_areset");
    chk("pre_areset_div1", 32'(strobe1[0]), 1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 chk_zero("areset");
    #1 reset_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("resettle_core_e%0d", e), 32'(core0), 32'(e >= 19));
      chk($sformatf("resettle_div1_e%0d", e), 32'(strobe1[0]), 32'(e >= 19));
      check_all("resettle");
    end
    run_cycles(10, "tail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_strobe_gen.md
CLOCK_STROBE_GEN -- requirements
Module: clock_strobe_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2: number of strobe channels, legal range 1..4.
REQ-002 The block SHALL have parameter DIV_W, default 10: divider counter width.
REQ-003 The block SHALL have parameter DIVS, default {10'd6,10'd4}: packed NUM_CH x DIV_W per-channel divisors, channel 0 in the LSBs, each divisor 1..2^DIV_W-1.
REQ-004 The block SHALL have parameter LOCK_WAIT, default 16: settle cycles after lock, legal range 1..255.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock (PLL output domain).
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port locked, input, 1 bit: raw PLL lock, asynchronous to clock.
REQ-008 The block SHALL have port lost_clear, input, 1 bit: clears the sticky lost_lock flag.
REQ-009 The block SHALL have port core_reset_n, output, 1 bit: lock-qualified active-low reset for downstream logic.
REQ-010 The block SHALL have port strobe, output, NUM_CH bits: one-cycle clock-enable pulse per channel.
REQ-011 The block SHALL have port lost_lock, output, 1 bit: sticky flag, set when lock is lost while in RUN.
REQ-012 The block SHALL have port loss_count, output, 8 bits: saturating count of lock losses.

Function
REQ-013 The block SHALL pass locked through a 2-flop synchroniser; the second flop is locked_sync.
REQ-014 The block SHALL implement FSM states WAIT_LOCK, SETTLE and RUN.
REQ-015 In WAIT_LOCK, locked_sync=1 SHALL move the FSM to SETTLE with the settle counter at 0.
REQ-016 In SETTLE, the settle counter SHALL increment each cycle; at count LOCK_WAIT-1 the next state SHALL be RUN.
REQ-017 In SETTLE, locked_sync=0 SHALL return the FSM to WAIT_LOCK and discard the settle count.
REQ-018 In RUN, locked_sync=0 SHALL move the FSM to WAIT_LOCK.
REQ-019 core_reset_n SHALL be a register, high exactly while the FSM is in RUN, updated on the same edge as the state.
REQ-020 Latency SHALL be: locked rising settles to core_reset_n high after exactly LOCK_WAIT+3 clock edges; locked falling in RUN drives core_reset_n low after exactly 3 edges.
REQ-021 Each channel i SHALL have a DIV_W counter: cleared outside RUN; counting 0..DIVS[i]-1 and wrapping to 0 in RUN.
REQ-022 strobe[i] SHALL be high exactly when the FSM is in RUN and counter i equals DIVS[i]-1.
REQ-023 A divisor of 1 SHALL hold strobe[i] high on every RUN cycle.
REQ-024 All channels SHALL be phase-aligned at RUN entry; the first strobe[i] SHALL occur on the DIVS[i]-th RUN cycle.
REQ-025 Strobes SHALL drop in the same cycle the FSM leaves RUN, with no partial or extra pulse.
REQ-026 lost_lock SHALL set on the RUN-to-WAIT_LOCK transition.
REQ-027 lost_lock SHALL clear when lost_clear=1.
REQ-028 When a set and lost_clear coincide, set SHALL win.
REQ-029 loss_count SHALL increment on each RUN-to-WAIT_LOCK transition and saturate at 255.
REQ-030 lost_clear SHALL NOT affect loss_count.
REQ-031 Lock loss during SETTLE SHALL NOT set lost_lock and SHALL NOT count.

Reset
REQ-032 reset_n low SHALL asynchronously force: FSM=WAIT_LOCK, synchroniser flops=0, settle and divider counters=0, core_reset_n=0, strobe=0, lost_lock=0, loss_count=0.
REQ-033 reset_n asserted mid-RUN SHALL drop core_reset_n and strobe immediately, without waiting for a clock edge.
REQ-034 After reset_n rises, the full settle sequence SHALL be repeated even if locked is already high.

Configuration
REQ-035 Macro CLOCK_STROBE_GEN_LOSS_COUNT_EN defined SHALL implement the loss_count counter per REQ-029.
REQ-036 Macro CLOCK_STROBE_GEN_LOSS_COUNT_EN undefined SHALL keep the loss_count port present but tied to 0, with no counter logic; all other behaviour SHALL be identical.

Verification
REQ-037 Bench SHALL cover lock-up: defaults, locked rises 1 ns after edge 0 -> core_reset_n high after edge 19; strobe[0] high after edges 22, 26, 30; strobe[1] high after edges 24, 30.
REQ-038 Bench SHALL cover a settle glitch: locked high for 5 cycles then low -> core_reset_n stays 0, lost_lock=0, loss_count=0; re-lock -> full 16-cycle settle from 0.
REQ-039 Bench SHALL cover lock loss in RUN: locked falls -> 3 edges later core_reset_n=0, strobe=0, lost_lock=1, loss_count=1; strobe drops with no truncated pulse.
REQ-040 Bench SHALL cover clear/set collision: lost_clear=1 on the same cycle as a RUN loss -> lost_lock=1; lost_clear alone next cycle -> lost_lock=0, loss_count unchanged.
REQ-041 Bench SHALL cover saturation and the macro: 260 loss cycles -> loss_count=255; with the macro undefined -> loss_count=0 throughout.
REQ-042 Bench SHALL cover async reset and DIV=1: reset_n pulsed low mid-RUN -> outputs zero before the next edge, re-settle takes 19 edges; with DIVS[0]=1 -> strobe[0] high on every RUN cycle.
